if_fetch_stage: RTL and testbench

//  Instruction-fetch control stage sitting between the PC register and the IF/ID boundary.

---
 rtl/if_fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch control stage: one outstanding imem request, registered IF/ID slot plus hold buffer.
// Optional stall counter port o_perf_stall_cnt when FETCH_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clk_en,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_pc_wr_en,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [DATA_W-1:0] i_imem_rdata,
    input  logic              i_flush,
    output logic              o_id_valid,
    output logic [DATA_W-1:0] o_id_instr,
    output logic [ADDR_W-1:0] o_id_pc,
    input  logic              i_id_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       o_perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FULL  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic              id_valid_r, id_valid_s;
    logic [DATA_W-1:0] id_instr_r, id_instr_s;
    logic [ADDR_W-1:0] id_pc_r, id_pc_s;
    logic [DATA_W-1:0] hold_instr_r, hold_instr_s;
    logic [ADDR_W-1:0] hold_pc_r, hold_pc_s;
    logic [ADDR_W-1:0] req_pc_r, req_pc_s;
    logic              load_s;
    logic [DATA_W-1:0] load_instr_s;
    logic [ADDR_W-1:0] load_pc_s;
    logic              xfer_s;
    logic              slot_free_s;

    assign xfer_s      = id_valid_r & i_id_ready;
    assign slot_free_s = ~id_valid_r | xfer_s;

    assign o_imem_addr = i_pc;
    assign o_imem_req  = i_rst_n & i_clk_en & (state_r == ST_REQ);
    // IDLE never writes the PC, even on a redirect, so the first fetch always uses the reset PC.
    assign o_pc_wr_en  = i_rst_n & i_clk_en & (state_r != ST_IDLE) &
                         (((state_r == ST_REQ) & i_imem_gnt & ~i_flush) | i_flush);

    assign o_id_valid  = id_valid_r;
    assign o_id_instr  = id_instr_r;
    assign o_id_pc     = id_pc_r;

    // Next-state and next IF/ID slot contents.
    always_comb begin
        state_s      = state_r;
        req_pc_s     = req_pc_r;
        hold_instr_s = hold_instr_r;
        hold_pc_s    = hold_pc_r;
        load_s       = 1'b0;
        load_instr_s = hold_instr_r;
        load_pc_s    = hold_pc_r;
        case (state_r)
            ST_IDLE: state_s = ST_REQ;
            ST_REQ: begin
                if (i_imem_gnt) begin
                    req_pc_s = i_pc;
                    state_s  = i_flush ? ST_DRAIN : ST_WAIT;
                end else begin
                    state_s  = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_imem_rvalid && i_flush) begin
                    state_s = ST_REQ;
                end else if (i_imem_rvalid && slot_free_s) begin
                    load_s       = 1'b1;
                    load_instr_s = i_imem_rdata;
                    load_pc_s    = req_pc_r;
                    state_s      = ST_REQ;
                end else if (i_imem_rvalid) begin
                    hold_instr_s = i_imem_rdata;
                    hold_pc_s    = req_pc_r;
                    state_s      = ST_FULL;
                end else begin
                    state_s = i_flush ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_FULL: begin
                if (i_flush) begin
                    state_s = ST_REQ;
                end else if (xfer_s) begin
                    load_s  = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_FULL;
                end
            end
            ST_DRAIN: state_s = i_imem_rvalid ? ST_REQ : ST_DRAIN;
            default:  state_s = ST_IDLE;
        endcase

        if (i_flush) begin
            id_valid_s = 1'b0;
            id_instr_s = NOP_INSTR;
            id_pc_s    = id_pc_r;
        end else if (load_s) begin
            id_valid_s = 1'b1;
            id_instr_s = load_instr_s;
            id_pc_s    = load_pc_s;
        end else if (xfer_s) begin
            id_valid_s = 1'b0;
            id_instr_s = NOP_INSTR;
            id_pc_s    = id_pc_r;
        end else begin
            id_valid_s = id_valid_r;
            id_instr_s = id_instr_r;
            id_pc_s    = id_pc_r;
        end
    end

    // State and IF/ID registers; everything freezes while the clock enable is low.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            id_valid_r   <= 1'b0;
            id_instr_r   <= NOP_INSTR;
            id_pc_r      <= {ADDR_W{1'b0}};
            hold_instr_r <= NOP_INSTR;
            hold_pc_r    <= {ADDR_W{1'b0}};
            req_pc_r     <= {ADDR_W{1'b0}};
        end else if (i_clk_en) begin
            state_r      <= state_s;
            id_valid_r   <= id_valid_s;
            id_instr_r   <= id_instr_s;
            id_pc_r      <= id_pc_s;
            hold_instr_r <= hold_instr_s;
            hold_pc_r    <= hold_pc_s;
            req_pc_r     <= req_pc_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_cnt_r;

    assign o_perf_stall_cnt = perf_cnt_r;

    // Counts enabled cycles with an empty IF/ID slot; wraps naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            perf_cnt_r <= 32'd0;
        end else if (i_clk_en && !id_valid_r) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: PC register + variable-latency memory environment, scoreboard model, directed vectors.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_clk_en, i_flush, i_id_ready;
    logic        i_imem_gnt, i_imem_rvalid;
    logic [31:0] i_pc, i_imem_rdata;
    logic        o_pc_wr_en, o_imem_req, o_id_valid;
    logic [31:0] o_imem_addr, o_id_instr, o_id_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_perf_stall_cnt;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    int          mem_lat;
    logic [31:0] flush_tgt;

    logic [31:0] pc_r;
    logic        mem_busy_r;
    int          mem_cnt_r;
    logic [31:0] mem_addr_r;

    if_fetch_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_en(i_clk_en), .i_pc(i_pc),
        .o_pc_wr_en(o_pc_wr_en), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .i_flush(i_flush), .o_id_valid(o_id_valid), .o_id_instr(o_id_instr), .o_id_pc(o_id_pc),
        .i_id_ready(i_id_ready)
`ifdef FETCH_PERF_CNT_EN
        , .o_perf_stall_cnt(o_perf_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory grants immediately and answers mem_lat enabled cycles later.
    assign i_pc          = pc_r;
    assign i_imem_gnt    = o_imem_req;
    assign i_imem_rvalid = mem_busy_r & (mem_cnt_r == 0) & i_clk_en;
    assign i_imem_rdata  = i_imem_rvalid ? instr_of(mem_addr_r) : 32'hxxxxxxxx;

    // PC register and memory environment.
    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_r       <= 32'h0;
            mem_busy_r <= 1'b0;
            mem_cnt_r  <= 0;
            mem_addr_r <= 32'h0;
        end else begin
            if (o_pc_wr_en) pc_r <= i_flush ? flush_tgt : pc_r + 32'd4;
            if (i_imem_gnt) begin
                mem_busy_r <= 1'b1;
                mem_cnt_r  <= mem_lat - 1;
                mem_addr_r <= o_imem_addr;
            end else if (i_imem_rvalid) begin
                mem_busy_r <= 1'b0;
            end else if (mem_busy_r && i_clk_en && mem_cnt_r != 0) begin
                mem_cnt_r <= mem_cnt_r - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model: expected decode stream, checked every cycle at the falling edge.
    initial begin : compare
        logic [31:0] q_pc[$];
        logic [31:0] q_in[$];
        bit          stale, p_known, p_hold, p_frozen, p_flush, p_deliver;
        logic        p_valid;
        logic [31:0] p_instr, p_pc, p_deliver_pc;
        logic [31:0] perf_exp;
        stale = 1'b0; p_known = 1'b0; p_hold = 1'b0; p_frozen = 1'b0;
        p_flush = 1'b0; p_deliver = 1'b0; perf_exp = 32'h0;
        p_valid = 1'b0; p_instr = NOP; p_pc = 32'h0; p_deliver_pc = 32'h0;
        @(posedge i_clk);
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                chk("rst_valid", {31'h0, o_id_valid}, 32'h0);
                chk("rst_instr", o_id_instr, NOP);
                chk("rst_req", {31'h0, o_imem_req}, 32'h0);
                chk("rst_pc_wr", {31'h0, o_pc_wr_en}, 32'h0);
                q_pc.delete(); q_in.delete();
                stale = 1'b0; p_known = 1'b0; perf_exp = 32'h0;
            end else begin
                if (!o_id_valid) chk("nop_when_invalid", o_id_instr, NOP);
                if (o_imem_req) chk("req_addr", o_imem_addr, i_pc);
                chk("pc_wr_en", {31'h0, o_pc_wr_en}, {31'h0, i_clk_en & (i_flush | i_imem_gnt)});
                if (!i_clk_en) chk("req_when_disabled", {31'h0, o_imem_req}, 32'h0);
                if (o_imem_req) chk("one_outstanding", {31'h0, mem_busy_r}, 32'h0);
                if (q_pc.size() >= 2) chk("no_req_when_full", {31'h0, o_imem_req}, 32'h0);
                if (p_known && (p_hold || p_frozen)) begin
                    chk("stable_valid", {31'h0, o_id_valid}, {31'h0, p_valid});
                    chk("stable_instr", o_id_instr, p_instr);
                    chk("stable_pc", o_id_pc, p_pc);
                end
                if (p_known && p_flush) chk("valid_after_flush", {31'h0, o_id_valid}, 32'h0);
                if (p_known && p_deliver) begin
                    chk("valid_latency", {31'h0, o_id_valid}, 32'h1);
                    chk("latency_pc", o_id_pc, p_deliver_pc);
                end
                if (o_id_valid) begin
                    if (q_pc.size() == 0) begin
                        chk("spurious_valid", {31'h0, o_id_valid}, 32'h0);
                    end else begin
                        chk("id_pc", o_id_pc, q_pc[0]);
                        chk("id_instr", o_id_instr, q_in[0]);
                    end
                end
`ifdef FETCH_PERF_CNT_EN
                chk("perf_cnt", o_perf_stall_cnt, perf_exp);
`endif
                p_known   = 1'b1;
                p_frozen  = !i_clk_en;
                p_hold    = i_clk_en && o_id_valid && !i_id_ready && !i_flush;
                p_flush   = i_clk_en && i_flush;
                p_valid   = o_id_valid;
                p_instr   = o_id_instr;
                p_pc      = o_id_pc;
                p_deliver = 1'b0;
                if (i_clk_en) begin
                    if (!o_id_valid) perf_exp = perf_exp + 32'd1;
                    if (i_imem_rvalid && !stale && !i_flush) begin
                        if (!o_id_valid || i_id_ready) begin
                            p_deliver    = 1'b1;
                            p_deliver_pc = mem_addr_r;
                        end
                    end
                    if (o_id_valid && i_id_ready && q_pc.size() > 0) begin
                        void'(q_pc.pop_front());
                        void'(q_in.pop_front());
                    end
                    if (i_imem_rvalid && !stale && !i_flush) begin
                        q_pc.push_back(mem_addr_r);
                        q_in.push_back(instr_of(mem_addr_r));
                    end
                    if (i_flush) begin
                        q_pc.delete(); q_in.delete();
                        stale = 1'b1;
                    end
                    if (i_imem_gnt) stale = i_flush;
                end
            end
        end
    end

    // Directed stimulus with hand-computed expectations at fixed cycles after reset release.
    initial begin : stim
        i_rst_n = 1'b0; i_clk_en = 1'b1; i_flush = 1'b0; i_id_ready = 1'b1;
        mem_lat = 1; flush_tgt = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk("t1_valid", {31'h0, o_id_valid}, 32'h0);
            chk("t1_instr", o_id_instr, 32'h00000013);
            chk("t1_req", {31'h0, o_imem_req}, 32'h0);
            chk("t1_pc_wr", {31'h0, o_pc_wr_en}, 32'h0);
        end
        i_rst_n = 1'b1;
        for (int r = 0; r < 40; r++) begin
            i_flush  = 1'b0;
            i_clk_en = 1'b1;
            case (r)
                7:              i_id_ready = 1'b0;
                13:             i_id_ready = 1'b1;
                14:             mem_lat = 3;
                15:             begin i_flush = 1'b1; flush_tgt = 32'h80; end
                16:             mem_lat = 1;
                21:             begin i_flush = 1'b1; flush_tgt = 32'h100; end
                22:             begin i_flush = 1'b1; flush_tgt = 32'h200; end
                25:             mem_lat = 3;
                26:             i_id_ready = 1'b0;
                27, 28, 29, 30: i_clk_en = 1'b0;
                31:             begin i_id_ready = 1'b1; mem_lat = 1; end
                default:        ;
            endcase
            #1;
            case (r)
                0:  chk("t2_idle_req", {31'h0, o_imem_req}, 32'h0);
                1:  begin
                        chk("t2_req", {31'h0, o_imem_req}, 32'h1);
                        chk("t2_addr0", o_imem_addr, 32'h0);
                        chk("t2_pc_wr", {31'h0, o_pc_wr_en}, 32'h1);
                    end
                2:  chk("t2_wait_valid", {31'h0, o_id_valid}, 32'h0);
                3:  begin
                        chk("t2_valid0", {31'h0, o_id_valid}, 32'h1);
                        chk("t2_pc0", o_id_pc, 32'h0);
                        chk("t2_instr0", o_id_instr, 32'hC0DE0000);
                    end
                4:  begin
                        chk("t2_gap_valid", {31'h0, o_id_valid}, 32'h0);
                        chk("t2_gap_nop", o_id_instr, 32'h00000013);
                    end
                5:  begin
                        chk("t2_pc1", o_id_pc, 32'h4);
                        chk("t2_instr1", o_id_instr, 32'hC0DE0004);
                    end
                7:  begin
                        chk("t2_valid2", {31'h0, o_id_valid}, 32'h1);
                        chk("t2_pc2", o_id_pc, 32'h8);
                        chk("t2_instr2", o_id_instr, 32'hC0DE0008);
                    end
                12: begin
                        chk("t3_held_valid", {31'h0, o_id_valid}, 32'h1);
                        chk("t3_held_pc", o_id_pc, 32'h8);
                        chk("t3_no_req", {31'h0, o_imem_req}, 32'h0);
                    end
                14: begin
                        chk("t3_next_valid", {31'h0, o_id_valid}, 32'h1);
                        chk("t3_next_pc", o_id_pc, 32'hC);
                        chk("t3_next_instr", o_id_instr, 32'hC0DE000C);
                    end
                18: begin
                        chk("t4_req", {31'h0, o_imem_req}, 32'h1);
                        chk("t4_addr", o_imem_addr, 32'h80);
                    end
                20: begin
                        chk("t4_valid", {31'h0, o_id_valid}, 32'h1);
                        chk("t4_pc", o_id_pc, 32'h80);
                    end
                22: begin
                        chk("t5_valid", {31'h0, o_id_valid}, 32'h0);
                        chk("t5_req", {31'h0, o_imem_req}, 32'h1);
                        chk("t5_addr", o_imem_addr, 32'h100);
                        chk("t5_pc_wr", {31'h0, o_pc_wr_en}, 32'h1);
                    end
                24: begin
                        chk("t5_req2", {31'h0, o_imem_req}, 32'h1);
                        chk("t5_addr2", o_imem_addr, 32'h200);
                        chk("t5_valid2", {31'h0, o_id_valid}, 32'h0);
                    end
                26: begin
                        chk("t5_valid3", {31'h0, o_id_valid}, 32'h1);
                        chk("t5_pc3", o_id_pc, 32'h200);
                    end
                30: begin
                        chk("t6_frozen_valid", {31'h0, o_id_valid}, 32'h1);
                        chk("t6_frozen_pc", o_id_pc, 32'h200);
                        chk("t6_req", {31'h0, o_imem_req}, 32'h0);
                        chk("t6_pc_wr", {31'h0, o_pc_wr_en}, 32'h0);
                    end
                34: begin
                        chk("t6_resume_valid", {31'h0, o_id_valid}, 32'h1);
                        chk("t6_resume_pc", o_id_pc, 32'h204);
                    end
                default: ;
            endcase
            @(posedge i_clk); #1;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
